// File: rtl/alu_pkg.sv
// Shared ALU datapath types: FSM states, slice width and result status flags.
package alu_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic bout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/bla_sub4.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = a - b - bin.
// Zero latency; no handshake.
module bla_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] brw;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Flat two-level lookahead: each borrow depends only on g, p and bin.
  assign brw[0] = bin;
  assign brw[1] = g[0] | (p[0] & bin);
  assign brw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign brw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bin);
  assign brw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d    = a ^ b ^ brw[3:0];
  assign bout = brw[4];

endmodule

// File: rtl/bla_sub_iter.sv
// Iterative subtractor, 4 bits/cycle: result SLICES cycles after accept, held until out_ready.
// Optional add mode (op port) under BLA_SUB_ADD_MODE_EN; in_ready only in IDLE, no queuing.
module bla_sub_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef BLA_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SLICES = WIDTH / SLICE_W;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int MSB    = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  generate
    if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("bla_sub_iter: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  flags_t           flags_q, flags_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] b_in;
  logic             bin_in;
  logic             final_bout;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_d;
  logic               sl_bout;

  // Add mode reuses the subtract slice as a - ~b - ~bin, so the stored
  // subtrahend is already inverted and the signed-overflow rule is shared.
`ifdef BLA_SUB_ADD_MODE_EN
  logic op_q, op_d;
  assign b_in       = op ? ~b : b;
  assign bin_in     = op ? ~bin : bin;
  assign final_bout = sl_bout ^ op_q;
`else
  assign b_in       = b;
  assign bin_in     = bin;
  assign final_bout = sl_bout;
`endif

  assign sl_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign sl_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

  bla_sub4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .bin  (brw_q),
    .d    (sl_d),
    .bout (sl_bout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    brw_d       = brw_q;
    acc_d       = acc_q;
    diff_d      = diff_q;
    flags_d     = flags_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef BLA_SUB_ADD_MODE_EN
    op_d        = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b_in;
          brw_d      = bin_in;
          idx_d      = '0;
`ifdef BLA_SUB_ADD_MODE_EN
          op_d       = op;
`endif
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d[int'(idx_q)*SLICE_W +: SLICE_W] = sl_d;
        brw_d = sl_bout;
        if (idx_q == LAST_IDX) begin
          diff_d       = acc_d;
          flags_d.bout = final_bout;
          flags_d.ovf  = (a_q[MSB] != b_q[MSB]) && (acc_d[MSB] != a_q[MSB]);
          flags_d.zero = (acc_d == '0);
          flags_d.neg  = acc_d[MSB];
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      brw_q       <= 1'b0;
      acc_q       <= '0;
      diff_q      <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BLA_SUB_ADD_MODE_EN
      op_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      brw_q       <= brw_d;
      acc_q       <= acc_d;
      diff_q      <= diff_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef BLA_SUB_ADD_MODE_EN
      op_q        <= op_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = flags_q.bout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;

endmodule

// File: tb/tb_bla_sub_iter.sv
// Self-checking bench for bla_sub_iter (WIDTH = 16): directed vectors, corner sequences, random vs model.
module tb_bla_sub_iter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         zero;
  logic         neg;
`ifdef BLA_SUB_ADD_MODE_EN
  logic         op_i;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bla_sub_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin_i),
`ifdef BLA_SUB_ADD_MODE_EN
    .op        (op_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_diff;
    logic [3:0]  exp_flags;   // {bout, ovf, zero, neg}
    string       name;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [3:0] flags_now();
    return {bout, ovf, zero, neg};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mbin, input logic mop);
    int u;
    int s;
    logic [15:0] d;
    logic bo;
    logic ov;
    if (mop) begin
      u  = int'(ma) + int'(mb) + int'(mbin);
      s  = int'($signed(ma)) + int'($signed(mb)) + int'(mbin);
      bo = (u > 65535);
    end else begin
      u  = int'(ma) - int'(mb) - int'(mbin);
      s  = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      bo = (u < 0);
    end
    d  = u[15:0];
    ov = (s > 32767) || (s < -32768);
    return {d, bo, ov, (d == 16'h0000), d[15]};
  endfunction

  // One operation; operands are scrambled right after accept to prove they are not resampled.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                        input int stall, output logic [15:0] rd, output logic [3:0] rf,
                        output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    a = ta; b = tb_v; bin_i = tbin;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin_i = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = diff;
    rf = flags_now();
    for (int i = 0; i < stall; i++) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("handshake_drop", out_valid, 0);
  endtask

  logic [15:0] rd;
  logic [3:0]  rf;
  int          lat;
  logic [19:0] exp;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rbin;
  logic        rop;
  int          hits;
  int          n;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin_i = 1'b0;
`ifdef BLA_SUB_ADD_MODE_EN
    op_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_state", {in_ready, out_valid, diff, flags_now()}, {1'b1, 1'b0, 16'h0000, 4'h0});
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 4'b0000, "basic"};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1001, "underflow"};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0100, "ovf_pos"};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 4'b1101, "ovf_neg"};
    vecs[4] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 4'b0010, "zero_bin"};
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, rd, rf, lat);
      check({vecs[i].name, "_diff"}, rd, vecs[i].exp_diff);
      check({vecs[i].name, "_flags"}, rf, vecs[i].exp_flags);
      check({vecs[i].name, "_lat"}, lat, 4);
    end

    // Back-to-back with in_valid held high throughout.
    a = 16'h5555; b = 16'h5554; bin_i = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    a = 16'hDEAD; b = 16'hBEEF; bin_i = 1'b0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      if (in_ready || out_valid) hits++;
      @(negedge clk);
    end
    check("b2b_busy", hits, 0);
    check("b2b_first", {out_valid, in_ready, diff, flags_now()}, {1'b1, 1'b0, 16'h0000, 4'b0010});
    a = 16'h0003; b = 16'h0001; bin_i = 1'b0;
    @(negedge clk);
    check("b2b_idle", {out_valid, in_ready}, {1'b0, 1'b1});
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_accept", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_lat", n, 4);
    check("b2b_second", {diff, flags_now()}, {16'h0002, 4'b0000});
    @(negedge clk);

    // Backpressure: three stalled DONE cycles.
    a = 16'h1234; b = 16'h0234; bin_i = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_lat", n, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, diff, flags_now()}, {1'b1, 1'b0, 16'h1000, 4'h0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {out_valid, in_ready, diff}, {1'b0, 1'b1, 16'h1000});

    // Reset after two RUN cycles abandons the operation.
    a = 16'hAAAA; b = 16'h1111; bin_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_run", {out_valid, diff, in_ready}, {1'b0, 16'h0000, 1'b1});
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check("rst_no_result", hits, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0, rd, rf, lat);
    check("rst_after_op", {rd, rf, 8'(lat)}, {16'hFFFF, 4'b1001, 8'd4});

`ifdef BLA_SUB_ADD_MODE_EN
    op_i = 1'b1;
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, rd, rf, lat);
    check("add_wrap", {rd, rf, 8'(lat)}, {16'h0000, 4'b1010, 8'd4});
    op_i = 1'b0;
`endif

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      rop = 1'b0;
`ifdef BLA_SUB_ADD_MODE_EN
      rop = 1'($urandom);
      op_i = rop;
`endif
      exp = model(ra, rb, rbin, rop);
      run_op(ra, rb, rbin, int'($urandom_range(0, 3)), rd, rf, lat);
      check("rand_diff", rd, exp[19:4]);
      check("rand_flags", rf, exp[3:0]);
      check("rand_lat", lat, 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bla_sub_iter.md
Name: bla_sub_iter

Overview:
- Iterative N-bit subtractor computing diff = a - b - bin, 4 bits per cycle.
- Each 4-bit slice uses a borrow-lookahead stage: borrow generate g = ~a & b, propagate p = ~(a ^ b).
- Complements the team's 4-bit carry-lookahead adder on the subtract side of the ALU datapath.
- Valid/ready handshakes on input and output; results carry ALU status flags.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4; elaboration error otherwise.
- SLICES, WIDTH/4, derived slice count. Local only, not overridable.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - bin, mod 2^WIDTH
- bout  output  1  borrow out of MSB; 1 when unsigned a < b + bin
- ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])
- zero  output  1  diff == 0
- neg  output  1  diff[MSB]

Behaviour:
- Reset: synchronous, checked on the rising edge of clk.
  - FSM goes to IDLE; slice index goes to 0.
  - in_ready = 1.
  - out_valid, diff, bout, ovf, zero and neg are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, register a, b and bin. Set the running borrow to bin and idx to 0, then go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, compute slice idx from the registered operands and the running borrow.
  - Write the slice result to diff[4*idx+3:4*idx] and update the running borrow. In-flight diff bits are internal; the port shows only the final value.
  - When idx == SLICES-1, register the final flags and go to DONE. Otherwise increment idx.
- DONE:
  - out_valid = 1.
  - diff and all flags stay stable until the cycle where out_valid && out_ready, then the FSM returns to IDLE.
  - On that return, out_valid drops to 0. diff and flags hold their last value.
- Latency: out_valid rises exactly SLICES cycles after the accept edge (4 cycles for WIDTH = 16). It is never earlier, and it is unaffected by out_ready.
- Throughput: one operation per SLICES + 2 cycles minimum.
  - There is no accept in the same cycle as a result handshake, because in_ready is 1 only in IDLE.
- in_valid while busy is ignored; operands are not queued.
- If out_ready is already high when DONE is entered, the handshake completes in the first DONE cycle.
- Operand inputs are sampled only at the accept edge. Changes afterwards have no effect.
- Reset mid-RUN or in DONE abandons the operation. The block is in IDLE with outputs 0 on the following cycle, and no result is emitted.
- Wrap-around: the result is mod 2^WIDTH, and bout flags the unsigned underflow.

Optional Feature:
- Macro: BLA_SUB_ADD_MODE_EN
- Enabled:
  - Adds input port `op` (1 bit), sampled at accept together with the operands.
  - op = 1 performs a + b + bin, with bin treated as carry in. The same slice computes a - ~b - ~bin.
  - In add mode, bout reports carry out, which is the inverted MSB borrow.
  - In add mode, ovf = (a[MSB] == b[MSB]) && (diff[MSB] != a[MSB]).
  - op = 0 behaves exactly as the subtract-only build.
- Disabled: the op port does not exist and the block subtracts only.

Decomposition:
- Shared package `alu_pkg`:
  - FSM state enum: IDLE, RUN, DONE.
  - Constant SLICE_W = 4.
  - Flags struct {bout, ovf, zero, neg}.
- One sub-module, `bla_sub4`: combinational 4-bit borrow-lookahead slice.
  - Inputs: a[3:0], b[3:0], bin.
  - Outputs: d[3:0], bout.
  - Borrows are computed in flat lookahead form: b1 = g0 | p0·bin, and so on up to b4.
- The top level holds the FSM, the operand registers, the slice mux and the flag logic.

Test Plan (WIDTH = 16):
- 0x1234 - 0x0234, bin = 0 -> diff 0x1000; bout 0, ovf 0, zero 0, neg 0; out_valid 4 cycles after the accept edge.
- 0x0000 - 0x0001 -> diff 0xFFFF; bout 1, neg 1, ovf 0, zero 0.
- 0x8000 - 0x0001 -> diff 0x7FFF; ovf 1, bout 0, neg 0. Then 0x7FFF - 0xFFFF -> diff 0x8000, ovf 1, bout 1.
- 0x5555 - 0x5554 with bin = 1 -> diff 0x0000, zero 1, bout 0. Then a back-to-back op:
  - in_valid held high, in_ready stays 0 until IDLE.
  - The second op is accepted on the cycle after the output handshake.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE -> out_valid, diff and flags stable, in_ready 0. Raise out_ready -> handshake, then IDLE with in_ready 1.
- Reset asserted after 2 RUN cycles -> next cycle out_valid 0, diff 0, in_ready 1. A new op then completes correctly. With BLA_SUB_ADD_MODE_EN: op = 1, 0xFFFF + 0x0001 -> diff 0x0000, bout (carry) 1, zero 1.
